// File: rtl/fetch_seq_unit_pkg.sv
// Shared constants and types for the PC/nPC fetch sequencer.
package fetch_seq_unit_pkg;

    localparam int          XLEN_DEF       = 32;
    localparam int          INST_BYTES_DEF = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0100_0000;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    // Which source loads pc/npc on the coming edge.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_SEQ,
        PC_REDIRECT,
        PC_FLUSH
    } pc_sel_e;

endpackage

// File: rtl/fetch_seq_unit_if.sv
// Fetch-side bus: instruction memory, redirect/flush inputs and the IF/ID register outputs.
interface fetch_seq_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            id_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_annul;
    logic            flush_valid;
    logic [XLEN-1:0] flush_target;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_npc;
    logic [31:0]     ifid_instr;

    modport master (
        output imem_addr, ifid_valid, ifid_pc, ifid_npc, ifid_instr,
        input  imem_rdata, id_ready, redirect_valid, redirect_target, redirect_annul,
               flush_valid, flush_target
    );

    modport slave (
        input  imem_addr, ifid_valid, ifid_pc, ifid_npc, ifid_instr,
        output imem_rdata, id_ready, redirect_valid, redirect_target, redirect_annul,
               flush_valid, flush_target
    );
endinterface

// File: rtl/fetch_seq_unit_pipe_reg_ce.sv
// W-bit pipeline register with sync reset, clear and clock enable (clear beats enable).
module fetch_seq_unit_pipe_reg_ce #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         ce,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= RST_VAL;
        end else if (ce) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/fetch_seq_unit.sv
// PC/nPC fetch sequencer with stall, pending redirect, delay-slot annul, trap flush and IF/ID register.
module fetch_seq_unit
    import fetch_seq_unit_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
    parameter int              INST_BYTES  = INST_BYTES_DEF,
    parameter int              DELAY_SLOTS = 1
) (
    input  logic              clk,
    input  logic              reset,
    fetch_seq_unit_if.master  bus
);
    localparam int              BW       = 2 * XLEN + 33;
    localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);
    localparam bit              DS       = (DELAY_SLOTS != 0);
    localparam logic [BW-1:0]   IFID_RST = {1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP_INSTR};

    logic [XLEN-1:0] pc_reg, npc_reg, pend_tgt_reg;
    logic            pend_v_reg, pend_annul_reg, annul_reg;
    logic            advance, rv, ra, cap_valid;
    logic [XLEN-1:0] rt;
    logic [31:0]     cap_instr;
    logic [BW-1:0]   ifid_d, ifid_q;
    pc_sel_e         pc_sel;

    always_comb begin
        advance   = !ifid_q[BW-1] || bus.id_ready;
        rv        = bus.redirect_valid || pend_v_reg;
        rt        = bus.redirect_valid ? bus.redirect_target : pend_tgt_reg;
        ra        = DS && (bus.redirect_valid ? bus.redirect_annul : pend_annul_reg);
        // Without a delay slot the word fetched alongside a redirect is wrong-path.
        cap_valid = !annul_reg && (DS || !rv);
        cap_instr = cap_valid ? bus.imem_rdata : NOP_INSTR;
        ifid_d    = {cap_valid, pc_reg, npc_reg, cap_instr};
        if (bus.flush_valid)  pc_sel = PC_FLUSH;
        else if (!advance)    pc_sel = PC_HOLD;
        else if (rv)          pc_sel = PC_REDIRECT;
        else                  pc_sel = PC_SEQ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            npc_reg        <= RESET_PC + STEP;
            pend_v_reg     <= 1'b0;
            pend_tgt_reg   <= '0;
            pend_annul_reg <= 1'b0;
            annul_reg      <= 1'b0;
        end else begin
            unique case (pc_sel)
                PC_FLUSH: begin
                    pc_reg     <= bus.flush_target;
                    npc_reg    <= bus.flush_target + STEP;
                    pend_v_reg <= 1'b0;
                    annul_reg  <= 1'b0;
                end
                PC_HOLD: begin
                    if (bus.redirect_valid) begin
                        pend_v_reg     <= 1'b1;
                        pend_tgt_reg   <= bus.redirect_target;
                        pend_annul_reg <= bus.redirect_annul;
                    end
                end
                PC_REDIRECT: begin
                    pend_v_reg <= 1'b0;
                    annul_reg  <= ra;
                    if (DS) begin
                        pc_reg  <= npc_reg;
                        npc_reg <= rt;
                    end else begin
                        pc_reg  <= rt;
                        npc_reg <= rt + STEP;
                    end
                end
                PC_SEQ: begin
                    pc_reg    <= npc_reg;
                    npc_reg   <= npc_reg + STEP;
                    annul_reg <= 1'b0;
                end
            endcase
        end
    end

    fetch_seq_unit_pipe_reg_ce #(
        .W       (BW),
        .RST_VAL (IFID_RST)
    ) u_ifid (
        .clk  (clk),
        .srst (reset),
        .ce   (advance),
        .clr  (bus.flush_valid),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign bus.imem_addr  = pc_reg;
    assign bus.ifid_valid = ifid_q[BW-1];
    assign bus.ifid_pc    = ifid_q[BW-2 -: XLEN];
    assign bus.ifid_npc   = ifid_q[32 +: XLEN];
    assign bus.ifid_instr = ifid_q[31:0];

    // A second redirect before the first has been applied overwrites it.
    redirect_overlap: assert property (@(posedge clk) disable iff (reset)
        !(bus.redirect_valid && pend_v_reg));

endmodule

// File: tb/tb_fetch_seq_unit.sv
// Three fetch sequencers (delay slot, no delay slot, wrapping reset PC) against a spec-level model.
module tb_fetch_seq_unit;
    import fetch_seq_unit_pkg::*;

    localparam logic [2:0]  DS_P  = 3'b101;
    localparam logic [95:0] RPC_P = {32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, id_ready = 1'b0;
    logic        redirect_valid = 1'b0, redirect_annul = 1'b0, flush_valid = 1'b0;
    logic [31:0] redirect_target = '0, flush_target = '0;
    logic [2:0][128:0] act;
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    function automatic logic [31:0] imem(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        fetch_seq_unit_if #(.XLEN(32)) bus ();
        assign bus.imem_rdata      = imem(bus.imem_addr);
        assign bus.id_ready        = id_ready;
        assign bus.redirect_valid  = redirect_valid;
        assign bus.redirect_target = redirect_target;
        assign bus.redirect_annul  = redirect_annul;
        assign bus.flush_valid     = flush_valid;
        assign bus.flush_target    = flush_target;
        fetch_seq_unit #(
            .XLEN        (32),
            .RESET_PC    (RPC_P[gi*32 +: 32]),
            .INST_BYTES  (4),
            .DELAY_SLOTS (int'(DS_P[gi]))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign act[gi] = {bus.imem_addr, bus.ifid_valid, bus.ifid_pc, bus.ifid_npc, bus.ifid_instr};
    end

    // Architectural view: fetch PC pair, pending redirect, annul flag and what ID currently holds.
    typedef struct packed {
        logic [31:0] pc, npc, pend_tgt, ifpc, ifnpc, ifinstr;
        logic        pend_v, pend_annul, annul, ifv;
    } mstate_t;
    mstate_t m [3];

    function automatic mstate_t mstep(mstate_t s, bit ds, logic [31:0] rpc);
        mstate_t     n;
        bit          rv, ra, live;
        logic [31:0] rt;
        n = s;
        if (reset) begin
            n = '0;
            n.pc = rpc;
            n.npc = rpc + 32'd4;
            n.ifinstr = NOP_INSTR;
            return n;
        end
        if (flush_valid) begin
            n.pc = flush_target;
            n.npc = flush_target + 32'd4;
            n.ifv = 1'b0; n.ifpc = '0; n.ifnpc = '0; n.ifinstr = NOP_INSTR;
            n.pend_v = 1'b0; n.annul = 1'b0;
            return n;
        end
        if (s.ifv && !id_ready) begin
            if (redirect_valid) begin
                n.pend_v = 1'b1; n.pend_tgt = redirect_target; n.pend_annul = redirect_annul;
            end
            return n;
        end
        rv = redirect_valid || s.pend_v;
        rt = redirect_valid ? redirect_target : s.pend_tgt;
        ra = redirect_valid ? redirect_annul : s.pend_annul;
        live = !s.annul && !(!ds && rv);
        n.ifv = live; n.ifpc = s.pc; n.ifnpc = s.npc;
        n.ifinstr = live ? imem(s.pc) : NOP_INSTR;
        n.annul = 1'b0;
        n.pend_v = 1'b0;
        if (!rv) begin
            n.pc = s.npc; n.npc = s.npc + 32'd4;
        end else if (ds) begin
            n.pc = s.npc; n.npc = rt; n.annul = ra;
        end else begin
            n.pc = rt; n.npc = rt + 32'd4;
        end
        return n;
    endfunction

    function automatic logic [128:0] exp_vec(mstate_t s);
        return {s.pc, s.ifv, s.ifpc, s.ifnpc, s.ifinstr};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (act[i] !== exp_vec(m[i])) begin
                    n_fail++;
                    $display("FAIL cycle_cmp dut%0d t=%0t: got addr/v/pc/npc/instr=%h, want %h",
                             i, $time, act[i], exp_vec(m[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = mstep(m[i], DS_P[i], RPC_P[i*32 +: 32]);
        check_en = 1'b1;
        #1;
    endtask

    task automatic lit(string name, int gi, logic v, logic [31:0] pc, logic [31:0] npc);
        logic [64:0] a, e;
        a = act[gi][96:32];
        e = {v, pc, npc};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d: got v/pc/npc=%h, want %h", name, gi, a, e);
        end else begin
            $display("%s dut%0d: v=%0b pc=%h npc=%h ok", name, gi, v, pc, npc);
        end
    endtask

    task automatic lit_nop(string name, int gi);
        logic [31:0] a;
        a = act[gi][31:0];
        n_checks++;
        if (a !== NOP_INSTR) begin
            n_fail++;
            $display("FAIL %s dut%0d: got instr=%h, want %h", name, gi, a, NOP_INSTR);
        end
    endtask

    task automatic lit_addr(string name, int gi, logic [31:0] addr);
        logic [31:0] a;
        a = act[gi][128:97];
        n_checks++;
        if (a !== addr) begin
            n_fail++;
            $display("FAIL %s dut%0d: got imem_addr=%h, want %h", name, gi, a, addr);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; flush_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        bit any_pend;

        // Sequential fetch, wrap, and a redirect at pc_q=8 seen by all three configurations
        do_reset();
        lit("rst_state", 0, 1'b0, 32'h0, 32'h0); lit_nop("rst_nop", 0);
        lit_addr("rst_addr", 2, 32'hFFFF_FFF8);
        tick(); lit("t1_pc0", 0, 1'b1, 32'd0, 32'd4);  lit("t7_f8", 2, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        tick(); lit("t1_pc4", 0, 1'b1, 32'd4, 32'd8);  lit("t7_fc", 2, 1'b1, 32'hFFFF_FFFC, 32'h0);
        redirect_valid = 1'b1; redirect_target = 32'd40; redirect_annul = 1'b0;
        tick(); redirect_valid = 1'b0;
        lit("t2_pc8", 0, 1'b1, 32'd8, 32'd12); lit("t6_kill", 1, 1'b0, 32'd8, 32'd12);
        lit_nop("t6_nop", 1); lit("t7_wrap0", 2, 1'b1, 32'd0, 32'd4);
        tick(); lit("t2_dslot", 0, 1'b1, 32'd12, 32'd40); lit("t6_tgt", 1, 1'b1, 32'd40, 32'd44);
        lit("t7_pc4", 2, 1'b1, 32'd4, 32'd40);
        tick(); lit("t2_tgt", 0, 1'b1, 32'd40, 32'd44);

        // Annulled delay slot
        do_reset(); tick(); tick();
        redirect_valid = 1'b1; redirect_target = 32'd40; redirect_annul = 1'b1;
        tick(); redirect_valid = 1'b0; redirect_annul = 1'b0;
        lit("t3_pc8", 0, 1'b1, 32'd8, 32'd12);
        tick(); lit("t3_annul", 0, 1'b0, 32'd12, 32'd40); lit_nop("t3_nop", 0);
        tick(); lit("t3_tgt", 0, 1'b1, 32'd40, 32'd44);

        // Redirect captured during a stall
        do_reset(); tick(); tick();
        id_ready = 1'b0;
        tick(); lit("t4_hold1", 0, 1'b1, 32'd4, 32'd8);
        redirect_valid = 1'b1; redirect_target = 32'd100;
        tick(); redirect_valid = 1'b0; lit("t4_hold2", 0, 1'b1, 32'd4, 32'd8);
        tick(); lit("t4_hold3", 0, 1'b1, 32'd4, 32'd8); lit_addr("t4_addr", 0, 32'd8);
        id_ready = 1'b1;
        tick(); lit("t4_rel", 0, 1'b1, 32'd8, 32'd12);
        tick(); lit("t4_dslot", 0, 1'b1, 32'd12, 32'd100);
        tick(); lit("t4_tgt", 0, 1'b1, 32'd100, 32'd104);

        // Flush while stalled with a redirect pending
        do_reset(); tick(); tick();
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'd100;
        tick(); redirect_valid = 1'b0;
        flush_valid = 1'b1; flush_target = 32'h80;
        tick(); flush_valid = 1'b0; lit("t5_flushed", 0, 1'b0, 32'h0, 32'h0); lit_nop("t5_nop", 0);
        tick(); lit("t5_vec", 0, 1'b1, 32'h80, 32'h84);
        id_ready = 1'b1;
        tick(); lit("t5_nopend", 0, 1'b1, 32'h84, 32'h88);

        // Reset mid-stall discards the pending redirect
        do_reset(); tick(); tick();
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'd100;
        tick(); redirect_valid = 1'b0;
        reset = 1'b1;
        tick(); reset = 1'b0; id_ready = 1'b1; lit("t8_rst", 0, 1'b0, 32'h0, 32'h0);
        tick(); lit("t8_pc0", 0, 1'b1, 32'd0, 32'd4);
        tick(); lit("t8_pc4", 0, 1'b1, 32'd4, 32'd8);

        // Randomised traffic, checked every cycle by the compare process
        for (int c = 0; c < 1500; c++) begin
            any_pend = m[0].pend_v || m[1].pend_v || m[2].pend_v;
            reset           = ($urandom_range(0, 99) == 0);
            flush_valid     = ($urandom_range(0, 15) == 0);
            flush_target    = $urandom & 32'hFFFF_FFFC;
            redirect_valid  = !any_pend && ($urandom_range(0, 4) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            redirect_annul  = 1'($urandom_range(0, 1));
            id_ready        = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
